// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD timer family.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Saturate an arbitrary nibble to a legal BCD digit.
  function automatic bcd_t bcd_clamp(bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down step chain.
// wrap_o flags that the digit sits on its wrap value for the current direction
// (0 when counting down, 9 when counting up); it is independent of step_i so the
// same signal serves both the ripple enable and the terminal-count detect.
module bcd_digit_step
  import timer_pkg::*;
(
  input  bcd_t digit_i,
  input  logic dir_i,
  input  logic step_i,
  output bcd_t digit_o,
  output logic wrap_o
);

  // Next value of this digit when stepped, plus its wrap-value flag.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wrap_o  = dir_i ? (digit_i >= BCD_MAX) : (digit_i == 4'd0);
    digit_o = digit_i;
    if (step_i) begin
      if (wrap_o) digit_o = dir_i ? 4'd0 : BCD_MAX;
      else        digit_o = dir_i ? digit_i + 4'd1 : digit_i - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer_n.sv
// N-digit BCD game timer / score counter.
// Counts down or up on a qualified tick, loads a clamped preset, accepts
// saturating BCD bonus additions, and works over a runtime-selectable number
// of low digits. Digits above the active range are held at zero.
module bcd_timer_n
  import timer_pkg::*;
#(
  parameter  int DIGITS = 6,
  localparam int AW     = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                loadN,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                enable1,
  input  logic                enable2,
  input  logic                dir,
  input  logic                add_en,
  input  logic [4*DIGITS-1:0] add_val,
  input  logic [AW-1:0]       active_digits,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                tc_pulse,
  output logic                sat
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                tc_pulse_q, tc_pulse_d;
  logic                sat_q, sat_d;

  logic [AW-1:0]       eff_digits;
  logic [DIGITS-1:0]   digit_mask;
  bcd_t                cur      [DIGITS];
  bcd_t                stepped  [DIGITS];
  bcd_t                sum      [DIGITS];
  logic [DIGITS-1:0]   wrap;
  logic [DIGITS-1:0]   step_in;
  logic                step_go;
  logic                add_carry;
  logic                stepped_term;
  bcd_t                term_digit;

  // Clamp the requested digit count to 1..DIGITS and build the in-use mask.
  always_comb begin
    if (active_digits == '0)                 eff_digits = AW'(1);
    else if (active_digits > AW'(DIGITS))    eff_digits = AW'(DIGITS);
    else                                     eff_digits = active_digits;
    for (int i = 0; i < DIGITS; i++) begin
      digit_mask[i] = (i < int'(eff_digits));
      cur[i]        = digit_mask[i] ? count_q[4*i +: 4] : 4'd0;
    end
  end

  // Terminal count: every in-use digit sits on its wrap value for this dir.
  assign tc         = &(wrap | ~digit_mask);
  assign step_go    = enable1 & enable2 & ~tc;
  assign term_digit = dir ? BCD_MAX : 4'd0;

  // Ripple step enable: a digit moves only when all lower digits wrap.
  always_comb begin
    step_in[0] = step_go;
    for (int i = 1; i < DIGITS; i++) step_in[i] = step_in[i-1] & wrap[i-1];
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit_i (cur[g]),
      .dir_i   (dir),
      .step_i  (step_in[g]),
      .digit_o (stepped[g]),
      .wrap_o  (wrap[g])
    );
  end

  // Does the stepped value land on the terminal value over the in-use digits?
  always_comb begin
    stepped_term = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_mask[i] && (stepped[i] != term_digit)) stepped_term = 1'b0;
    end
  end

  // Decimal ripple adder with +6 correction; records the carry out of the top in-use digit.
  always_comb begin
    logic       carry;
    logic [4:0] s;
    bcd_t       b;
    carry     = 1'b0;
    add_carry = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      b = digit_mask[i] ? bcd_clamp(add_val[4*i +: 4]) : 4'd0;
      s = 5'(cur[i]) + 5'(b) + 5'(carry);
      if (s > 5'd9) begin
        sum[i] = 4'(s + 5'd6);
        carry  = 1'b1;
      end else begin
        sum[i] = s[3:0];
        carry  = 1'b0;
      end
      if (i == int'(eff_digits) - 1) add_carry = carry;
    end
  end

  // Next-state selection: load beats add beats step; dropped requests are lost.
  always_comb begin
    tc_pulse_d = 1'b0;
    sat_d      = 1'b0;
    for (int i = 0; i < DIGITS; i++) count_d[4*i +: 4] = cur[i];
    if (!loadN) begin
      for (int i = 0; i < DIGITS; i++)
        count_d[4*i +: 4] = digit_mask[i] ? bcd_clamp(load_val[4*i +: 4]) : 4'd0;
    end else if (add_en) begin
      sat_d = add_carry;
      for (int i = 0; i < DIGITS; i++) begin
        if (!digit_mask[i]) count_d[4*i +: 4] = 4'd0;
        else if (add_carry) count_d[4*i +: 4] = BCD_MAX;
        else                count_d[4*i +: 4] = sum[i];
      end
    end else if (step_go) begin
      tc_pulse_d = stepped_term;
      for (int i = 0; i < DIGITS; i++)
        count_d[4*i +: 4] = digit_mask[i] ? stepped[i] : 4'd0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetN) begin
      count_q    <= '0;
      tc_pulse_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_pulse_q <= tc_pulse_d;
      sat_q      <= sat_d;
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_pulse_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_bcd_timer_n.sv
// Self-checking bench for bcd_timer_n: directed scenarios followed by random
// traffic, all compared against an integer-valued reference model.
module tb_bcd_timer_n;

  localparam int DIGITS = 6;
  localparam int AW     = $clog2(DIGITS + 1);

  logic                clk = 1'b0;
  logic                resetN;
  logic                loadN;
  logic [4*DIGITS-1:0] load_val;
  logic                enable1, enable2, dir, add_en;
  logic [4*DIGITS-1:0] add_val;
  logic [AW-1:0]       active_digits;
  logic [4*DIGITS-1:0] count;
  logic                tc, tc_pulse, sat;

  int    n_checks = 0;
  int    n_errors = 0;
  longint m_val   = 0;   // model: count as a plain decimal integer

  bcd_timer_n #(.DIGITS(DIGITS)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .loadN         (loadN),
    .load_val      (load_val),
    .enable1       (enable1),
    .enable2       (enable2),
    .dir           (dir),
    .add_en        (add_en),
    .add_val       (add_val),
    .active_digits (active_digits),
    .count         (count),
    .tc            (tc),
    .tc_pulse      (tc_pulse),
    .sat           (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_e();
    int e = int'(active_digits);
    if (e < 1) e = 1;
    if (e > DIGITS) e = DIGITS;
    return e;
  endfunction

  function automatic longint pow10(int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Integer value of the low e digits of a nibble vector, each nibble clamped to 9.
  function automatic longint bcd2int(input logic [4*DIGITS-1:0] v, input int e);
    longint r = 0;
    int d;
    for (int i = e - 1; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] int2bcd(input longint x);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One clock: check tc on current inputs, predict, clock, then check outputs.
  task automatic tick();
    int     e;
    longint md, vm, term, nv, s;
    bit     m_tc, exp_pulse, exp_sat, valid;
    #1;
    e    = eff_e();
    md   = pow10(e);
    vm   = m_val % md;
    term = dir ? md - 1 : 0;
    m_tc = (vm == term);
    check("tc", tc, m_tc);
    exp_pulse = 0;
    exp_sat   = 0;
    if (!loadN) begin
      nv = bcd2int(load_val, e);
    end else if (add_en) begin
      s = vm + bcd2int(add_val, e);
      if (s >= md) begin nv = md - 1; exp_sat = 1; end
      else nv = s;
    end else if (enable1 && enable2 && !m_tc) begin
      nv = dir ? vm + 1 : vm - 1;
      exp_pulse = (nv == term);
    end else begin
      nv = vm;
    end
    @(posedge clk);
    #1;
    m_val = nv;
    check("count", count, int2bcd(m_val));
    check("tc_pulse", tc_pulse, exp_pulse);
    check("sat", sat, exp_sat);
    valid = 1;
    for (int i = 0; i < DIGITS; i++) if (count[4*i +: 4] > 4'd9) valid = 0;
    check("bcd_valid", valid, 1);
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v);
    loadN = 1'b0; load_val = v;
    tick();
    loadN = 1'b1;
  endtask

  int pulses;
  int sats;

  initial begin
    resetN = 1'b0; loadN = 1'b1; load_val = '0; enable1 = 0; enable2 = 0;
    dir = 0; add_en = 0; add_val = '0; active_digits = AW'(6);
    #12;
    check("reset_count", count, 0);
    check("reset_tc", tc, 1);
    check("reset_pulse", tc_pulse, 0);
    check("reset_sat", sat, 0);
    resetN = 1'b1;
    @(posedge clk); #1;

    // 1: count down 120 -> 0, single pulse, then hold.
    do_load(24'h000120);
    enable1 = 1; enable2 = 1;
    pulses = 0;
    for (int i = 0; i < 123; i++) begin
      tick();
      if (tc_pulse) pulses++;
    end
    check("t1_count", count, 24'h000000);
    check("t1_pulses", pulses, 1);
    check("t1_tc", tc, 1);

    // 2: fuel mode, 3 digits.
    enable1 = 0;
    active_digits = AW'(3);
    do_load(24'h999050);
    check("t2_load", count, 24'h000050);
    enable1 = 1;
    for (int i = 0; i < 50; i++) tick();
    check("t2_count", count, 24'h000000);
    check("t2_tc", tc, 1);

    // 3: count up, 2 digits, third step ignored.
    enable1 = 0; dir = 1;
    active_digits = AW'(2);
    do_load(24'h000097);
    enable1 = 1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tc_pulse) pulses++;
    end
    check("t3_count", count, 24'h000099);
    check("t3_pulses", pulses, 1);

    // 4: saturating and non-saturating adds.
    enable1 = 0; dir = 0;
    active_digits = AW'(4);
    do_load(24'h009990);
    add_en = 1; add_val = 24'h000025;
    tick();
    check("t4_sat_count", count, 24'h009999);
    check("t4_sat", sat, 1);
    add_en = 0;
    do_load(24'h000178);
    add_en = 1;
    tick();
    check("t4_add_count", count, 24'h000203);
    check("t4_nosat", sat, 0);
    add_en = 0;

    // 5: priority load > add > step.
    enable1 = 1; enable2 = 1;
    loadN = 0; load_val = 24'h000500; add_en = 1; add_val = 24'h000011;
    tick();
    check("t5_load_wins", count, 24'h000500);
    loadN = 1;
    tick();
    check("t5_add_no_step", count, 24'h000511);
    add_en = 0;

    // 6: invalid nibble clamps, then async reset mid-count.
    active_digits = AW'(6);
    do_load(24'h00000C);
    check("t6_clamp", count, 24'h000009);
    do_load(24'h000300);
    for (int i = 0; i < 5; i++) tick();
    #2 resetN = 1'b0;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_pulse", tc_pulse, 0);
    m_val = 0;
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;

    // Random traffic against the model.
    sats = 0;
    for (int n = 0; n < 1500; n++) begin
      loadN   = ($urandom_range(0, 24) != 0);
      add_en  = ($urandom_range(0, 9) == 0);
      enable1 = ($urandom_range(0, 7) != 0);
      enable2 = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) active_digits = AW'($urandom_range(0, 7));
      for (int i = 0; i < DIGITS; i++) begin
        load_val[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
        add_val[4*i +: 4]  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      end
      tick();
      if (sat) sats++;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
